// File: rtl/ks16_adder_if.sv
// Operand/result bus for ks16_adder.
// The OVF signal exists only when KS16_OVF_EN is defined.
interface ks16_adder_if;
  logic [15:0] A;
  logic [15:0] B;
  logic        CIN;
  logic [15:0] SUM;
  logic        COUT;
`ifdef KS16_OVF_EN
  logic        OVF;
`endif

  // Operand source side.
  modport master (
    output A, B, CIN,
`ifdef KS16_OVF_EN
    input  OVF,
`endif
    input  SUM, COUT
  );

  // Adder side.
  modport slave (
    input  A, B, CIN,
`ifdef KS16_OVF_EN
    output OVF,
`endif
    output SUM, COUT
  );
endinterface

// File: rtl/ks16_adder.sv
// ks16_adder: three-stage pipelined 16-bit Kogge-Stone adder, SUM/COUT = A + B + CIN.
// Stage p0 registers generate/propagate with CIN folded into bit 0.
// Stage p1 registers prefix levels 1 and 2.
// Stage p2 registers prefix levels 4 and 8 together with the final sum.
// Optional feature: define KS16_OVF_EN to add the registered signed-overflow output OVF.
// Reset is synchronous and active-high on RST_N. It clears every pipeline register.
module ks16_adder (
  input  logic         CLK,
  input  logic         RST_N,
  ks16_adder_if.slave  bus
);

  localparam int DATA_W = 16;

  // Apply one full-width Kogge-Stone level at distance d.
  // Bits below d keep their (G,P) unchanged, because the shifted-in terms are zero or masked.
  function automatic logic [2*DATA_W-1:0] ks_level(input logic [DATA_W-1:0] g,
                                                   input logic [DATA_W-1:0] p,
                                                   input int              d);
    logic [DATA_W-1:0] gs, ps, lo_mask, go, po;
    gs      = g << d;
    ps      = p << d;
    lo_mask = (DATA_W'(1) << d) - DATA_W'(1);
    go      = g | (p & gs);
    po      = p & (ps | lo_mask);
    return {go, po};
  endfunction

  logic [DATA_W-1:0] p_p0, g_p0;
  logic              cin_p0;
  logic [DATA_W-1:0] gg_p1, pp_p1, p_p1;
  logic              cin_p1;
  logic [DATA_W-1:0] sum_p2;
  logic              cout_p2;

  logic [DATA_W-1:0] g_l1, p_l1, g_l2, p_l2;
  logic [DATA_W-1:0] g_l4, p_l4, g_l8, p_l8;
  logic [DATA_W-1:0] sum_nxt;

`ifdef KS16_OVF_EN
  logic a15_p0, b15_p0, a15_p1, b15_p1, ovf_p2;
`endif

  // ---- stage p0: bitwise generate/propagate, carry-in folded into bit 0 ----
  // Register p, g and CIN. CIN is kept because SUM[0] needs it.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      p_p0   <= '0;
      g_p0   <= '0;
      cin_p0 <= 1'b0;
    end else begin
      p_p0   <= bus.A ^ bus.B;
      g_p0   <= (bus.A & bus.B) |
                {{(DATA_W-1){1'b0}}, (bus.A[0] ^ bus.B[0]) & bus.CIN};
      cin_p0 <= bus.CIN;
    end
  end

  // Prefix levels at distances 1 and 2.
  always_comb begin
    {g_l1, p_l1} = ks_level(g_p0, p_p0, 1);
    {g_l2, p_l2} = ks_level(g_l1, p_l1, 2);
  end

  // ---- stage p1: prefix after levels 1 and 2 ----
  // The raw propagate bits travel along so the sum can be formed in the last stage.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      gg_p1  <= '0;
      pp_p1  <= '0;
      p_p1   <= '0;
      cin_p1 <= 1'b0;
    end else begin
      gg_p1  <= g_l2;
      pp_p1  <= p_l2;
      p_p1   <= p_p0;
      cin_p1 <= cin_p0;
    end
  end

  // Prefix levels at distances 4 and 8. After these, g_l8[i] is the carry out of bit i.
  always_comb begin
    {g_l4, p_l4} = ks_level(gg_p1, pp_p1, 4);
    {g_l8, p_l8} = ks_level(g_l4, p_l4, 8);
    sum_nxt      = p_p1 ^ {g_l8[DATA_W-2:0], cin_p1};
  end

  // ---- stage p2: registered sum and carry-out ----
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
    end else begin
      sum_p2  <= sum_nxt;
      cout_p2 <= g_l8[DATA_W-1];
    end
  end

  assign bus.SUM  = sum_p2;
  assign bus.COUT = cout_p2;

`ifdef KS16_OVF_EN
  // Pipeline the operand sign bits so overflow lines up with its own sum.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      a15_p0 <= 1'b0;
      b15_p0 <= 1'b0;
      a15_p1 <= 1'b0;
      b15_p1 <= 1'b0;
      ovf_p2 <= 1'b0;
    end else begin
      a15_p0 <= bus.A[DATA_W-1];
      b15_p0 <= bus.B[DATA_W-1];
      a15_p1 <= a15_p0;
      b15_p1 <= b15_p0;
      ovf_p2 <= (a15_p1 == b15_p1) && (sum_nxt[DATA_W-1] != a15_p1);
    end
  end

  assign bus.OVF = ovf_p2;
`endif

endmodule

// File: tb/tb_ks16_adder.sv
// Randomized self-checking bench for ks16_adder.
// The reference model is arithmetic A+B+CIN on the operands sampled three edges earlier.
// The expected output is forced to zero if reset was seen on any of those three edges.
module tb_ks16_adder;

  logic CLK = 1'b0;
  logic RST_N;

  ks16_adder_if bus ();

  ks16_adder dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  logic [16:0] res_q[$];
  logic        ovf_q[$];
  bit          rst_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one operand set, let it be sampled, then compare outputs 1 time unit after the edge.
  task automatic cycle(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic r);
    logic [16:0] res;
    logic [16:0] exp_res;
    logic        exp_ovf;
    logic        flushed;
    bus.A   = a;
    bus.B   = b;
    bus.CIN = c;
    RST_N   = r;
    @(posedge CLK);
    res = {1'b0, a} + {1'b0, b} + {16'b0, c};
    res_q.push_back(res);
    ovf_q.push_back((a[15] == b[15]) && (res[15] != a[15]));
    rst_q.push_back(r);
    if (res_q.size() > 3) begin
      void'(res_q.pop_front());
      void'(ovf_q.pop_front());
      void'(rst_q.pop_front());
    end
    #1;
    flushed = (res_q.size() < 3);
    foreach (rst_q[i]) if (rst_q[i]) flushed = 1'b1;
    exp_res = flushed ? 17'h0 : res_q[0];
    exp_ovf = flushed ? 1'b0 : ovf_q[0];
    check({tag, ".sum"},  32'(bus.SUM),  32'(exp_res[15:0]));
    check({tag, ".cout"}, 32'(bus.COUT), 32'(exp_res[16]));
`ifdef KS16_OVF_EN
    check({tag, ".ovf"},  32'(bus.OVF),  32'(exp_ovf));
`else
    if (exp_ovf) begin end
`endif
  endtask

  initial begin
    // Reset held for two cycles with random operands; outputs must stay zero afterwards too.
    cycle("rst0", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    cycle("rst1", 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);

    // Directed operands (results appear on later cycles of the same sequence).
    cycle("d_1111_2222", 16'h1111, 16'h2222, 1'b1, 1'b0);
    cycle("d_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    cycle("d_ffff_0000", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    cycle("d_0001_0001", 16'h0001, 16'h0001, 1'b0, 1'b0);
    cycle("d_8000_8000", 16'h8000, 16'h8000, 1'b0, 1'b0);
    cycle("d_1234_4321", 16'h1234, 16'h4321, 1'b1, 1'b0);
    cycle("d_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    cycle("d_0000_0000", 16'h0000, 16'h0000, 1'b0, 1'b0);

    // One-cycle reset while three operations are in flight.
    cycle("fl_a", 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    cycle("fl_b", 16'h7FFF, 16'h7FFF, 1'b1, 1'b0);
    cycle("fl_c", 16'hC000, 16'hC000, 1'b0, 1'b0);
    cycle("fl_rst", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      cycle("fl_after", 16'h0F0F, 16'hF0F1, 1'b0, 1'b0);

    // Randomized traffic with occasional resets and carry-chain corner operands.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a, b;
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = ~a;
        1: a = 16'hFFFF;
        2: b = 16'h8000;
        default: ;
      endcase
      cycle("rnd", a, b, 1'($urandom), 1'($urandom_range(0, 40) == 0));
    end

    // Drain the pipeline.
    for (int i = 0; i < 3; i++)
      cycle("drain", 16'h0000, 16'h0000, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ks16_adder.md
# ks16_adder

Pipelined 16-bit Kogge-Stone parallel-prefix adder with carry-in and carry-out. It computes A + B + CIN with a fixed three-cycle latency and accepts a new operand set every clock. It is the arithmetic leaf of the datapath and drives registered outputs directly into downstream logic.

## Interface
- No parameters; width fixed at 16.
- CLK  input  1  sole clock; all state updates on rising edge.
- RST_N  input  1  reset is synchronous and active-high: asserted when 1 and sampled on the CLK rising edge; the name keeps the codebase's port naming.
- A  input  16  addend.
- B  input  16  addend.
- CIN  input  1  carry-in to bit 0.
- SUM  output  16  registered (A + B + CIN) mod 2^16.
- COUT  output  1  registered carry out of bit 15.
- OVF  output  1  registered signed overflow; present only with KS16_OVF_EN.

## Operation
- Stage 1 (pre-process, registered):
  - p[i] = A[i]^B[i]; g[i] = A[i]&B[i], for i = 0..15.
  - CIN folded into bit 0 as g0' = g[0] | (p[0]&CIN).
  - p and CIN also registered for the sum stage.
- Stage 2 (prefix levels 1 and 2, registered):
  - Black cell: (G,P) = (Gi | Pi&Gj, Pi&Pj), with j = i-1, then j = i-2.
  - Bits with i < distance pass through unchanged.
- Stage 3 (prefix levels 4 and 8 plus sum, registered):
  - After level 8, G[i] is the carry out of bit i.
  - SUM[0] = p[0]^CIN; SUM[i] = p[i]^G[i-1]; COUT = G[15].
- Pure Kogge-Stone: all 4 levels full-width, no sparse or ripple segments.
- Arithmetic is unsigned modulo 2^16; COUT carries the 17th bit.
- No handshake: every cycle's inputs are a valid transaction.

## Timing
- Latency 3 cycles: inputs sampled at edge N appear on SUM/COUT after edge N+2 and are stable through edge N+3.
- Throughput: 1 result per cycle; back-to-back operands never interact.
- Reset (RST_N=1 at an edge) clears every pipeline register: SUM=0, COUT=0, OVF=0, and all intermediate G/P/CIN copies = 0.
- Reset mid-flight discards all in-flight operations.
- Outputs stay 0 until 3 edges after the first post-reset input sample.
- Inputs sampled on the same edge that reset is asserted are discarded.
- X on inputs is not filtered; it propagates to outputs 3 cycles later.

## Configuration
- KS16_OVF_EN defined: OVF port exists.
  - OVF = (A[15]==B[15]) & (SUM[15]!=A[15]), using the sampled operands.
  - Sign bits are pipelined with the data so OVF aligns with the matching SUM.
  - OVF resets to 0.
- KS16_OVF_EN undefined: no OVF port and no sign-bit pipeline registers; all other behaviour identical.

## Test plan
- Hold RST_N=1 for 2 cycles with random inputs -> SUM=0000, COUT=0 throughout, and still 0 for 2 cycles after release.
- A=1111, B=2222, CIN=1 -> SUM=3334, COUT=0 exactly 3 edges after sampling.
- A=FFFF, B=FFFF, CIN=1 -> SUM=FFFF, COUT=1; A=FFFF, B=0000, CIN=1 -> SUM=0000, COUT=1 (full carry chain).
- Back-to-back per cycle: (0001+0001+0) -> 0002/0; (8000+8000+0) -> 0000/1; (1234+4321+1) -> 5556/0 -> results on consecutive cycles in order.
- Assert RST_N for 1 cycle while 3 operations are in flight -> outputs 0 next cycle; no stale result ever appears.
- With KS16_OVF_EN: 7FFF+0001+0 -> SUM=8000, OVF=1, COUT=0; 8000+8000+0 -> OVF=1, COUT=1; 0001+0001+0 -> OVF=0.
